// File: rtl/kamacore_pkg.sv
// Shared kamacore widths and the in-flight pipeline slot payload.
package kamacore_pkg;

    localparam int unsigned CPU_WIDTH      = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    // One in-flight instruction as seen by the forwarding logic.
    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      is_load;
        logic                      data_valid;
        logic [CPU_WIDTH-1:0]      data;
    } st_inflight_slot;

endpackage

// File: rtl/kamacore_forward_mux.sv
// Per-operand priority match across EX, MEM and WB with load-use stall request.
module kamacore_forward_mux
    import kamacore_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] rs_a,
    input  logic [CPU_WIDTH-1:0]      rs_data_original,
    input  st_inflight_slot           ex_slot,
    input  st_inflight_slot           mem_slot,
    input  st_inflight_slot           wb_slot,
    input  logic [CPU_WIDTH-1:0]      ex_result_data,
    input  logic                      mem_load_valid,
    input  logic [CPU_WIDTH-1:0]      mem_load_data,
    output logic [CPU_WIDTH-1:0]      data_c,
    output logic                      stall_c
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // EX result is taken live from the ALU, so the slot's stored data is never read here.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{ex_slot.data_valid, ex_slot.data,
                                wb_slot.is_load, wb_slot.data_valid};

    // x0 never matches, so it always falls through to the register file value.
    assign ex_hit  = ex_slot.valid  && ex_slot.we  && (ex_slot.rd  == rs_a) && (rs_a != '0);
    assign mem_hit = mem_slot.valid && mem_slot.we && (mem_slot.rd == rs_a) && (rs_a != '0);
    assign wb_hit  = wb_slot.valid  && wb_slot.we  && (wb_slot.rd  == rs_a) && (rs_a != '0);

    // Youngest producer wins; loads without data yet request a stall.
    always_comb begin
        data_c  = rs_data_original;
        stall_c = 1'b0;
        if (ex_hit) begin
            data_c  = ex_result_data;
            stall_c = ex_slot.is_load;
        end else if (mem_hit) begin
            data_c = mem_slot.data;
            if (mem_slot.is_load && !mem_slot.data_valid) begin
                if (mem_load_valid) begin
                    data_c = mem_load_data;
                end else begin
                    stall_c = 1'b1;
                end
            end
        end else if (wb_hit) begin
            data_c = wb_slot.data;
        end
    end

endmodule

// File: rtl/kamacore_forwarding_unit.sv
// Operand forwarding and load-use hazard control over three in-flight slots.
module kamacore_forwarding_unit
    import kamacore_pkg::*;
#(
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0]  issue_rd_a,
    input  logic                       issue_is_load,
    input  logic                       flush,
    input  logic [CPU_WIDTH-1:0]       ex_result_data,
    input  logic                       mem_load_valid,
    input  logic [CPU_WIDTH-1:0]       mem_load_data,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_a,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_a,
    input  logic [CPU_WIDTH-1:0]       rs1_data_original,
    input  logic [CPU_WIDTH-1:0]       rs2_data_original,
    output logic [CPU_WIDTH-1:0]       rs1_data_forwarded,
    output logic [CPU_WIDTH-1:0]       rs2_data_forwarded,
    output logic                       stall,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    st_inflight_slot ex_q;
    st_inflight_slot mem_q;
    st_inflight_slot wb_q;
    st_inflight_slot issue_slot;
    st_inflight_slot ex_to_mem;
    st_inflight_slot mem_eff;
    logic            mem_ready;
    logic            rs1_stall_c;
    logic            rs2_stall_c;

    kamacore_forward_mux u_fwd_rs1 (
        .rs_a             (rs1_a),
        .rs_data_original (rs1_data_original),
        .ex_slot          (ex_q),
        .mem_slot         (mem_q),
        .wb_slot          (wb_q),
        .ex_result_data   (ex_result_data),
        .mem_load_valid   (mem_load_valid),
        .mem_load_data    (mem_load_data),
        .data_c           (rs1_data_forwarded),
        .stall_c          (rs1_stall_c)
    );

    kamacore_forward_mux u_fwd_rs2 (
        .rs_a             (rs2_a),
        .rs_data_original (rs2_data_original),
        .ex_slot          (ex_q),
        .mem_slot         (mem_q),
        .wb_slot          (wb_q),
        .ex_result_data   (ex_result_data),
        .mem_load_valid   (mem_load_valid),
        .mem_load_data    (mem_load_data),
        .data_c           (rs2_data_forwarded),
        .stall_c          (rs2_stall_c)
    );

    assign stall = rs1_stall_c | rs2_stall_c;

    // A pending MEM load blocks MEM/WB from advancing during a stall.
    assign mem_ready = !mem_q.valid || !mem_q.is_load || mem_q.data_valid;

    // Next-slot payloads: fresh issue, EX moving to MEM, MEM with returned load data merged.
    always_comb begin
        issue_slot            = '0;
        issue_slot.valid      = issue_valid;
        issue_slot.we         = issue_rd_we;
        issue_slot.rd         = issue_rd_a;
        issue_slot.is_load    = issue_is_load;

        ex_to_mem             = ex_q;
        ex_to_mem.data        = ex_result_data;
        ex_to_mem.data_valid  = !ex_q.is_load;

        mem_eff = mem_q;
        if (mem_q.valid && mem_q.is_load && !mem_q.data_valid && mem_load_valid) begin
            mem_eff.data_valid = 1'b1;
            mem_eff.data       = mem_load_data;
        end
    end

    // Slot pipeline: flush beats stall beats normal shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (flush) begin
            ex_q.valid  <= 1'b0;
            mem_q.valid <= 1'b0;
        end else if (!stall) begin
            ex_q  <= issue_slot;
            mem_q <= ex_to_mem;
            wb_q  <= mem_eff;
        end else if (mem_ready) begin
            ex_q  <= '0;
            mem_q <= ex_to_mem;
            wb_q  <= mem_eff;
        end else begin
            mem_q <= mem_eff;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end

endmodule
